// File: rtl/cache_fill_ctrl_pkg.sv
// Shared constants and state encoding for the cache miss-fill / write-through controller.
package cache_pkg;

  localparam int BLOCK_WORDS       = 8;
  localparam int WORD_OFFSET_BITS  = 3;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int CNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    TAG   = 2'b10,
    STORE = 2'b11
  } fill_state_t;

endpackage

// File: rtl/cache_fill_ctrl_counter.sv
// Block word counter: clear, enable, saturates at BLOCK_WORDS and flags completion.
module fill_word_counter
  import cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  output logic [WORD_OFFSET_BITS-1:0] word,
  output logic                        done
);

  logic [CNT_W-1:0] cnt;

  // Count state; holds once the full block has been counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (en && !done) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= cnt;
    end
  end

  assign done = (cnt == 4'(BLOCK_WORDS));
  assign word = cnt[WORD_OFFSET_BITS-1:0];

endmodule

// File: rtl/cache_fill_ctrl.sv
// Per-cache miss-fill and write-through controller between the cache arrays and
// the shared memory arbiter.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        miss_detected,
  input  logic [ADDR_W-1:0]           miss_address,
  input  logic                        store_req,
  input  logic [ADDR_W-1:0]           store_addr,
  input  logic [15:0]                 store_data,
  input  logic                        grant,
  input  logic [15:0]                 mem_data_out,
  input  logic                        mem_valid,
  output logic                        filling,
  output logic                        mem_enable,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [15:0]                 mem_data_in,
  output logic                        fsm_busy,
  output logic                        write_data_array,
  output logic [WORD_OFFSET_BITS-1:0] data_word_sel,
  output logic [15:0]                 data_array_wdata,
  output logic                        write_tag_array,
  output logic                        store_done
);

  localparam int BLK_W = ADDR_W - BLOCK_OFFSET_BITS;

  fill_state_t                 state;
  fill_state_t                 nxt;
  logic [BLK_W-1:0]            blk;
  logic [ADDR_W-1:0]           st_addr;
  logic [15:0]                 st_data;
  logic                        store_pend;

  logic                        start_fill;
  logic                        issue_en;
  logic                        recv_en;
  logic [WORD_OFFSET_BITS-1:0] issue_word;
  logic [WORD_OFFSET_BITS-1:0] recv_word;
  logic                        issue_done;
  logic                        recv_done;

  assign start_fill = (state == IDLE) && miss_detected;
  // Both counters only move while the arbiter is serving us, so a lost grant just pauses the fill.
  assign issue_en   = (state == FILL) && grant && !issue_done;
  assign recv_en    = (state == FILL) && grant && mem_valid && !recv_done;

  fill_word_counter u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_fill),
    .en   (issue_en),
    .word (issue_word),
    .done (issue_done)
  );

  fill_word_counter u_recv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_fill),
    .en   (recv_en),
    .word (recv_word),
    .done (recv_done)
  );

  // State register plus block / pending-store capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      blk        <= '0;
      st_addr    <= '0;
      st_data    <= 16'h0000;
      store_pend <= 1'b0;
    end else begin
      state <= nxt;
      if (start_fill) begin
        blk        <= miss_address[ADDR_W-1:BLOCK_OFFSET_BITS];
        store_pend <= store_req;
        st_addr    <= store_addr;
        st_data    <= store_data;
      end else if ((state == IDLE) && store_req) begin
        st_addr <= store_addr;
        st_data <= store_data;
      end else if ((state == STORE) && grant) begin
        store_pend <= 1'b0;
      end else begin
        store_pend <= store_pend;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    nxt              = state;
    filling          = 1'b0;
    mem_enable       = 1'b0;
    mem_write        = 1'b0;
    mem_address      = '0;
    mem_data_in      = 16'h0000;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    data_word_sel    = '0;
    write_tag_array  = 1'b0;
    store_done       = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          nxt = FILL;
        end else if (store_req) begin
          nxt = STORE;
        end else begin
          nxt = IDLE;
        end
      end
      FILL: begin
        filling  = 1'b1;
        fsm_busy = 1'b1;
        if (!issue_done) begin
          mem_enable  = grant;
          mem_address = {blk, issue_word, 1'b0};
        end else begin
          mem_enable  = 1'b0;
          mem_address = '0;
        end
        if (recv_en) begin
          write_data_array = 1'b1;
          data_word_sel    = recv_word;
        end else begin
          write_data_array = 1'b0;
        end
        // Leave as the last word lands so the tag write follows immediately.
        if (recv_en && (recv_word == 3'(BLOCK_WORDS - 1))) begin
          nxt = TAG;
        end else begin
          nxt = FILL;
        end
      end
      TAG: begin
        write_tag_array = 1'b1;
        fsm_busy        = 1'b1;
        if (store_pend) begin
          nxt = STORE;
        end else begin
          nxt = IDLE;
        end
      end
      STORE: begin
        filling     = 1'b1;
        fsm_busy    = 1'b1;
        mem_write   = 1'b1;
        mem_address = st_addr;
        mem_data_in = st_data;
        mem_enable  = grant;
        if (grant) begin
          store_done = 1'b1;
          nxt        = IDLE;
        end else begin
          nxt = STORE;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  assign data_array_wdata = mem_data_out;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl with a 4-stage pipelined memory model.
module tb_cache_fill_ctrl;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
  } iss_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        store_req;
  logic [15:0] store_addr;
  logic [15:0] store_data;
  logic        grant;
  logic [15:0] mem_data_out;
  logic        mem_valid;
  logic        filling;
  logic        mem_enable;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_data_in;
  logic        fsm_busy;
  logic        write_data_array;
  logic [2:0]  data_word_sel;
  logic [15:0] data_array_wdata;
  logic        write_tag_array;
  logic        store_done;
  logic        stray;

  iss_t        iss_q[$];
  logic [18:0] wr_q[$];
  logic        ms_q[$];   // milestones: 0 = tag write, 1 = store done
  iss_t        me;
  logic [18:0] mw;
  logic        mk;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_wr_seen = 0;

  logic [3:0]  pv;
  logic [15:0] pa [4];

  cache_fill_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .store_req        (store_req),
    .store_addr       (store_addr),
    .store_data       (store_data),
    .grant            (grant),
    .mem_data_out     (mem_data_out),
    .mem_valid        (mem_valid),
    .filling          (filling),
    .mem_enable       (mem_enable),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .fsm_busy         (fsm_busy),
    .write_data_array (write_data_array),
    .data_word_sel    (data_word_sel),
    .data_array_wdata (data_array_wdata),
    .write_tag_array  (write_tag_array),
    .store_done       (store_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mdat(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory: read accepted while granted returns 4 granted cycles later.
  always @(posedge clk) begin
    if (rst) begin
      pv <= 4'd0;
      for (int i = 0; i < 4; i++) pa[i] <= 16'h0000;
    end else if (grant) begin
      pv    <= {pv[2:0], mem_enable & ~mem_write};
      pa[0] <= mem_address;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end

  assign mem_valid    = (pv[3] & grant) | stray;
  assign mem_data_out = mdat(pa[3]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL unexpected_%s: actual event at %0t, required none", name, $time);
  endtask

  function automatic logic [63:0] outs();
    return 64'({filling, mem_enable, mem_write, mem_address, mem_data_in, fsm_busy,
                write_data_array, data_word_sel, write_tag_array, store_done});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_fill(input logic [15:0] addr);
    logic [15:0] wa;
    for (int i = 0; i < 8; i++) begin
      wa = {addr[15:4], 3'(i), 1'b0};
      iss_q.push_back('{w: 1'b0, a: wa, d: 16'h0000});
      wr_q.push_back({3'(i), mdat(wa)});
    end
    ms_q.push_back(1'b0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((iss_q.size() + wr_q.size() + ms_q.size()) != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    check({name, "_drained"}, 64'(iss_q.size() + wr_q.size() + ms_q.size()), 64'd0);
    #1;
  endtask

  initial begin
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0000; store_req = 1'b0;
    store_addr = 16'h0000; store_data = 16'h0000; grant = 1'b0; stray = 1'b0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (mem_enable) begin
            if (iss_q.size() == 0) unexpected("mem_access");
            else begin
              me = iss_q.pop_front();
              check("mem_write", 64'(mem_write), 64'(me.w));
              check("mem_address", 64'(mem_address), 64'(me.a));
              check("mem_data_in", 64'(mem_data_in), 64'(me.d));
            end
          end
          if (write_data_array) begin
            n_wr_seen++;
            if (wr_q.size() == 0) unexpected("data_write");
            else begin
              mw = wr_q.pop_front();
              check("data_word_sel", 64'(data_word_sel), 64'(mw[18:16]));
              check("data_array_wdata", 64'(data_array_wdata), 64'(mw[15:0]));
            end
          end
          if (write_tag_array) begin
            if (ms_q.size() == 0) unexpected("tag_write");
            else begin
              mk = ms_q.pop_front();
              check("milestone_tag", 64'd0, 64'(mk));
            end
          end
          if (store_done) begin
            if (ms_q.size() == 0) unexpected("store_done");
            else begin
              mk = ms_q.pop_front();
              check("milestone_store_done", 64'd1, 64'(mk));
            end
          end
        end
      end
    join_none

    tick(3);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Uncontested fill of block 0x123.
    miss_detected = 1'b1; miss_address = 16'h1236; grant = 1'b1;
    push_fill(16'h1236);
    tick(1);
    miss_detected = 1'b0;
    tick(8);
    @(negedge clk);
    check("fill_tail", 64'({filling, mem_enable, mem_address, fsm_busy}), {46'd0, 1'b1, 1'b0, 16'h0000, 1'b1});
    tick(4);
    @(negedge clk);
    check("tag_cycle13", 64'({write_tag_array, fsm_busy, filling}), 64'b110);
    tick(1);
    @(negedge clk);
    check("busy_after_tag", 64'({fsm_busy, filling}), 64'd0);
    drain("fill_basic");

    // Grant lost for 5 cycles after the third issue.
    miss_detected = 1'b1; miss_address = 16'h1236; grant = 1'b1;
    push_fill(16'h1236);
    tick(1);
    miss_detected = 1'b0;
    tick(3);
    grant = 1'b0;
    @(negedge clk);
    check("grant_loss_hold", 64'({mem_enable, write_data_array, fsm_busy, filling}), 64'b0011);
    tick(5);
    grant = 1'b1;
    drain("fill_grant_loss");

    // Store-only write-through.
    store_req = 1'b1; store_addr = 16'h0040; store_data = 16'hBEEF; grant = 1'b1;
    iss_q.push_back('{w: 1'b1, a: 16'h0040, d: 16'hBEEF});
    ms_q.push_back(1'b1);
    tick(1);
    store_req = 1'b0; store_addr = 16'hFFFF; store_data = 16'h0000;
    @(negedge clk);
    check("store_cycle", 64'({mem_write, mem_enable, fsm_busy, filling, store_done}), 64'b11111);
    tick(1);
    @(negedge clk);
    check("store_back_idle", outs(), 64'd0);
    drain("store_only");

    // Same-cycle miss and store: fill, tag, then write-through.
    miss_detected = 1'b1; miss_address = 16'h2000; store_req = 1'b1;
    store_addr = 16'h2004; store_data = 16'hC0DE; grant = 1'b1;
    push_fill(16'h2000);
    iss_q.push_back('{w: 1'b1, a: 16'h2004, d: 16'hC0DE});
    ms_q.push_back(1'b1);
    tick(1);
    miss_detected = 1'b0; store_req = 1'b0; store_addr = 16'h0000; store_data = 16'h0000;
    drain("miss_then_store");

    // Reset after the fourth received word aborts the fill.
    miss_detected = 1'b1; miss_address = 16'h3450; grant = 1'b1;
    push_fill(16'h3450);
    begin
      int target;
      int k;
      target = n_wr_seen + 4;
      tick(1);
      miss_detected = 1'b0;
      k = 0;
      while (n_wr_seen < target && k < 100) begin
        @(posedge clk);
        k++;
      end
      check("words_before_reset", 64'(n_wr_seen >= target), 64'd1);
      #1;
    end
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    check("abort_outputs", outs(), 64'd0);
    iss_q.delete();
    wr_q.delete();
    ms_q.delete();
    tick(1);
    rst = 1'b0;
    miss_detected = 1'b1; miss_address = 16'h3450;
    push_fill(16'h3450);
    tick(1);
    miss_detected = 1'b0;
    drain("refill_after_reset");

    // Stray valid while grant is low must not write.
    miss_detected = 1'b1; miss_address = 16'h4A10; grant = 1'b1;
    push_fill(16'h4A10);
    tick(1);
    miss_detected = 1'b0;
    tick(5);
    grant = 1'b0; stray = 1'b1;
    @(negedge clk);
    check("stray_no_write", 64'(write_data_array), 64'd0);
    tick(1);
    stray = 1'b0;
    tick(1);
    grant = 1'b1;
    drain("stray_valid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Per-cache miss-handling and write-through controller, one instance for the I-cache and one for the D-cache.
- Sits between the cache tag/data arrays and the shared main-memory arbiter.
- On a miss it raises `filling` toward the arbiter, streams 8 word reads of the 16-byte block, writes each returned word into the data array, then writes the tag.
- It also issues single-word write-through stores.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block (block = 16 bytes).
- ADDR_W, 16, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  16  byte address of the missing access
- store_req  in  1  write-through request (D-cache only; tie 0 for I-cache)
- store_addr  in  16  store byte address
- store_data  in  16  store data
- grant  in  1  arbiter is servicing this cache this cycle (arbiter's per-cache stall output)
- mem_data_out  in  16  memory read data (already gated by the arbiter)
- mem_valid  in  1  memory read data valid (already gated by the arbiter)
- filling  out  1  memory access requested, to the arbiter
- mem_enable  out  1  memory enable
- mem_write  out  1  memory write
- mem_address  out  16  memory address
- mem_data_in  out  16  memory write data
- fsm_busy  out  1  stall the pipeline
- write_data_array  out  1  data-array word write strobe
- data_word_sel  out  3  word index within the block
- data_array_wdata  out  16  equals mem_data_out
- write_tag_array  out  1  tag and valid write strobe
- store_done  out  1  write-through accepted (1-cycle pulse)

Behaviour:
- Clocking: all state updates on the rising edge of clk. rst is synchronous and active-high.
- Reset: state=IDLE, both counters 0, store_pend=0. All outputs 0, including mem_address.
- States:
  - IDLE
  - FILL: issue and receive overlap.
  - TAG: 1 cycle.
  - STORE
- IDLE:
  - miss_detected=1 → latch blk = miss_address[15:4], clear both counters, latch store_pend=store_req with its addr/data, go to FILL.
  - else store_req=1 → latch store addr/data, go to STORE.
  - fsm_busy=0 in IDLE.
- FILL:
  - filling=1 and fsm_busy=1 throughout.
  - While issue_cnt<8: mem_enable=grant, mem_write=0, mem_address={blk, issue_cnt[2:0], 1'b0}. issue_cnt increments only when grant=1.
  - Once issue_cnt=8: mem_enable=0 and mem_address=0; filling stays 1 until all 8 words are received.
  - Each cycle with mem_valid=1 and grant=1: write_data_array=1, data_word_sel=recv_cnt[2:0], recv_cnt increments.
  - mem_valid is ignored while grant=0. A stray valid when recv_cnt=8 is ignored.
  - Memory is pipelined with 4-cycle latency, so an uncontested fill spans 12 cycles from the first grant.
  - recv_cnt reaching 8 → go to TAG.
- TAG:
  - write_tag_array=1, fsm_busy=1, filling=0.
  - Next state: STORE if store_pend=1, else IDLE.
- STORE:
  - filling=1, mem_write=1, mem_address=latched store_addr, mem_data_in=latched store_data, mem_enable=grant.
  - On grant: store_done=1 for that cycle, clear store_pend, go to IDLE.
  - fsm_busy=1 while in STORE.
- Grant loss mid-fill (arbiter serving the other cache): issue and receive pause, counters hold, no words are lost or duplicated.
- miss_detected/store_req outside IDLE: ignored, except the store captured on the IDLE→FILL transition.
- Same-cycle miss and store in IDLE: fill first, then write-through.
- rst asserted mid-FILL or mid-STORE: abort. Next cycle is IDLE with all outputs 0; no tag write occurs.
- Counters: issue_cnt and recv_cnt are 4 bits, saturating at 8, never wrap.
- mem_data_in=0 whenever mem_write=0.

Decomposition:
- Shared package cache_pkg:
  - BLOCK_WORDS=8, WORD_OFFSET_BITS=3, BLOCK_OFFSET_BITS=4
  - state encoding IDLE=2'b00, FILL=2'b01, TAG=2'b10, STORE=2'b11
- One sub-module, fill_word_counter: 4-bit counter with clear, enable, saturate-at-8 and done flag. Instantiated twice, for issue and recv.

Test Plan:
- Miss at 0x1236 with grant held 1 → mem_address issues 0x1230,0x1232,…,0x123E on consecutive cycles; 8 write_data_array pulses with data_word_sel 0..7; write_tag_array on cycle 13; fsm_busy falls the next cycle.
- Same miss, grant dropped for 5 cycles after the 3rd issue → issue resumes at 0x1236; exactly 8 data writes in order 0..7; one tag write.
- Store-only at 0x0040 with data 0xBEEF, grant=1 → one cycle of mem_write=1, mem_enable=1, mem_address=0x0040, mem_data_in=0xBEEF; store_done pulse; back to IDLE.
- Miss at 0x2000 and store at 0x2004 in the same cycle → full fill, TAG, then STORE to 0x2004; store_done after write_tag_array.
- rst asserted after the 4th received word → next cycle all outputs 0, state IDLE; no write_tag_array; a following miss restarts at word 0.
- Stray mem_valid with grant=0 during FILL → no data write, recv_cnt unchanged.
